// File: rtl/banco_registradores.sv
// Register file feeding the ALU operands, with write-back port and architectural zero flag.
// r0 reads as zero. Reads are combinational; writes and flag capture happen on the rising edge.
module banco_registradores #(
  parameter int LARGURA  = 8,
  parameter int NUM_REGS = 8,
  parameter int ENDERECO = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [ENDERECO-1:0] RegLeitura1,
  input  logic [ENDERECO-1:0] RegLeitura2,
  input  logic [ENDERECO-1:0] RegEscrita,
  input  logic [LARGURA-1:0]  DadoEscrita,
  input  logic                EscreveReg,
  input  logic                ZeroULA,
  input  logic                AtualizaFlag,
  output logic [LARGURA-1:0]  Dado1,
  output logic [LARGURA-1:0]  Dado2,
  output logic                FlagZero
);

  logic [LARGURA-1:0] regs_q [NUM_REGS];
  logic [LARGURA-1:0] regs_d [NUM_REGS];
  logic               flag_q;
  logic               flag_d;

  always_comb begin
    regs_d = regs_q;
    flag_d = flag_q;
    // r0 is never written, so its flop stays at the reset value of zero
    if (EscreveReg && (RegEscrita != '0)) begin
      regs_d[RegEscrita] = DadoEscrita;
    end
    if (AtualizaFlag) begin
      flag_d = ZeroULA;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      regs_q <= '{default: '0};
      flag_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      flag_q <= flag_d;
    end
  end

  // Reads see stored state only: a same-cycle write is visible after the edge
  assign Dado1    = (RegLeitura1 == '0) ? '0 : regs_q[RegLeitura1];
  assign Dado2    = (RegLeitura2 == '0) ? '0 : regs_q[RegLeitura2];
  assign FlagZero = flag_q;

endmodule
